// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM controller arbiter.
// One-hot state encoding, command codes and the pin-bundle struct.
package sdram_pkg;

  localparam int ADDR_W = 11;
  localparam int BA_W   = 2;
  localparam int DATA_W = 32;
  localparam int DQM_W  = 4;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int IDX_INIT  = 0;
  localparam int IDX_ARBIT = 1;
  localparam int IDX_AREF  = 2;
  localparam int IDX_WRITE = 3;
  localparam int IDX_READ  = 4;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [BA_W-1:0]   ba;
  } cmd_bus_t;

  // Grant counter must at least reach the timeout value
  function automatic int cnt_w(int n);
    return ($clog2(n + 1) > 10) ? $clog2(n + 1) : 10;
  endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// Registered SDRAM pin mux: the client bundle selected by the
// current arbiter state appears on the pins one clock later.
module sdram_cmd_mux
  import sdram_pkg::*;
(
  input  logic              sclk,
  input  logic              srst_n,
  input  state_t            state,
  input  cmd_bus_t          init_bus,
  input  cmd_bus_t          aref_bus,
  input  cmd_bus_t          wr_bus,
  input  cmd_bus_t          rd_bus,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_oe_n,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [DATA_W-1:0] sdram_data,
  output logic              sdram_oe_n,
  output logic [DQM_W-1:0]  sdram_dqm
);

  cmd_bus_t nop_bus;

  assign nop_bus   = '{cmd: CMD_NOP, addr: '0, ba: '0};
  assign sdram_dqm = '0;

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      {sdram_cmd, sdram_addr, sdram_ba} <= nop_bus;
      sdram_data <= '0;
      sdram_oe_n <= 1'b1;
    end else begin
      sdram_data <= '0;
      sdram_oe_n <= 1'b1;
      unique case (1'b1)
        state[IDX_INIT]:
          {sdram_cmd, sdram_addr, sdram_ba} <= init_bus;
        state[IDX_AREF]:
          {sdram_cmd, sdram_addr, sdram_ba} <= aref_bus;
        state[IDX_WRITE]: begin
          {sdram_cmd, sdram_addr, sdram_ba} <= wr_bus;
          sdram_data <= wr_data;
          sdram_oe_n <= wr_oe_n;
        end
        state[IDX_READ]:
          {sdram_cmd, sdram_addr, sdram_ba} <= rd_bus;
        default:
          {sdram_cmd, sdram_addr, sdram_ba} <= nop_bus;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init hold, then aref > write > read.
// Define SDRAM_ARB_RR_EN to alternate write/read when both pend.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_oe_n,
  input  logic              aref_req,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              aref_done,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_ack,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [DATA_W-1:0] sdram_data,
  output logic              sdram_oe_n,
  output logic [DQM_W-1:0]  sdram_dqm,
  output logic              arb_err
);

  localparam int CNT_W = cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             in_grant;
  logic             timeout;
  logic             pick_rd;

  assign in_grant = state[IDX_AREF] | state[IDX_WRITE] |
                    state[IDX_READ];
  assign timeout  = in_grant && (cnt == CNT_MAX);
  assign arb_err  = timeout;
  assign aref_ack = aref_en;

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;

  // Read wins a write/read tie only if write was served last
  assign pick_rd = rd_req & (~wr_req | last_wr);

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      last_wr <= 1'b0;
    end else if (state[IDX_ARBIT]) begin
      if (nxt == ST_WRITE) last_wr <= 1'b1;
      else if (nxt == ST_READ) last_wr <= 1'b0;
    end
  end
`else
  assign pick_rd = rd_req & ~wr_req;
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_INIT:
        if (init_end) nxt = ST_ARBIT;
      ST_ARBIT:
        if (aref_req)    nxt = ST_AREF;
        else if (pick_rd) nxt = ST_READ;
        else if (wr_req) nxt = ST_WRITE;
      ST_AREF:
        if (aref_done || timeout) nxt = ST_ARBIT;
      ST_WRITE:
        if (wr_done || timeout) nxt = ST_ARBIT;
      ST_READ:
        if (rd_done || timeout) nxt = ST_ARBIT;
      default:
        nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state   <= ST_INIT;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= nxt;
      aref_en <= (nxt == ST_AREF);
      wr_en   <= (nxt == ST_WRITE);
      rd_en   <= (nxt == ST_READ);
      if (!in_grant)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  sdram_cmd_mux u_mux (
    .sclk       (sclk),
    .srst_n     (srst_n),
    .state      (state),
    .init_bus   ({init_cmd, init_addr, init_ba}),
    .aref_bus   ({aref_cmd, aref_addr, aref_ba}),
    .wr_bus     ({wr_cmd, wr_addr, wr_ba}),
    .rd_bus     ({rd_cmd, rd_addr, rd_ba}),
    .wr_data    (wr_data),
    .wr_oe_n    (wr_oe_n),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .sdram_data (sdram_data),
    .sdram_oe_n (sdram_oe_n),
    .sdram_dqm  (sdram_dqm)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: stimulus queues expected
// grants/pins for a future cycle, a negedge monitor checks them.
module tb_sdram_arbit;

  localparam int TO = 1023;

  localparam int P_NONE = 0;
  localparam int P_NOP  = 1;
  localparam int P_INIT = 2;
  localparam int P_AREF = 3;
  localparam int P_WR   = 4;
  localparam int P_RD   = 5;

`ifdef SDRAM_ARB_RR_EN
  localparam logic [2:0] ALT1 = 3'b001;
`else
  localparam logic [2:0] ALT1 = 3'b010;
`endif

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [10:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [31:0] wr_data;
  logic        wr_oe_n;
  logic        aref_req, wr_req, rd_req;
  logic        aref_done, wr_done, rd_done;
  logic        aref_en, wr_en, rd_en, aref_ack;
  logic [3:0]  sdram_cmd;
  logic [10:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [31:0] sdram_data;
  logic        sdram_oe_n;
  logic [3:0]  sdram_dqm;
  logic        arb_err;

  sdram_arbit #(.TIMEOUT_CYC(TO)) dut (
    .sclk(sclk), .srst_n(srst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_ba(aref_ba),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .wr_data(wr_data), .wr_oe_n(wr_oe_n),
    .aref_req(aref_req), .wr_req(wr_req), .rd_req(rd_req),
    .aref_done(aref_done), .wr_done(wr_done), .rd_done(rd_done),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .aref_ack(aref_ack), .sdram_cmd(sdram_cmd),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_data(sdram_data), .sdram_oe_n(sdram_oe_n),
    .sdram_dqm(sdram_dqm), .arb_err(arb_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    string       name;
    int          cyc;
    logic [2:0]  en;
    logic        err;
    bit          pins;
    logic [3:0]  cmd;
    logic [10:0] addr;
    logic [1:0]  ba;
    logic [31:0] data;
    logic        oe_n;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic expect_at(string nm, int c, logic [2:0] en,
                           logic err, int sel);
    exp_t e;
    e.name = nm; e.cyc = c; e.en = en; e.err = err;
    e.pins = (sel != P_NONE);
    e.cmd = 4'b0111; e.addr = '0; e.ba = '0;
    e.data = '0; e.oe_n = 1'b1;
    case (sel)
      P_INIT: begin e.cmd = 4'b0010; e.addr = 11'h400; e.ba = 2'd1; end
      P_AREF: begin e.cmd = 4'b0001; e.addr = 11'h011; e.ba = 2'd2; end
      P_WR: begin
        e.cmd = 4'b0100; e.addr = 11'h0aa; e.ba = 2'd3;
        e.data = 32'hdeadbeef; e.oe_n = 1'b0;
      end
      P_RD: begin e.cmd = 4'b0101; e.addr = 11'h055; e.ba = 2'd1; end
      default: ;
    endcase
    q.push_back(e);
  endtask

  always @(negedge sclk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        exp_t e;
        logic bad;
        e = q[i];
        q.delete(i);
        nvec++;
        bad = (e.cyc != cyc) ||
              ({aref_en, wr_en, rd_en} !== e.en) ||
              (aref_ack !== e.en[2]) || (arb_err !== e.err);
        if (e.pins)
          bad = bad || (sdram_cmd !== e.cmd) ||
                (sdram_addr !== e.addr) || (sdram_ba !== e.ba) ||
                (sdram_data !== e.data) ||
                (sdram_oe_n !== e.oe_n) || (sdram_dqm !== 4'h0);
        if (bad) begin
          nerr++;
          $display("FAIL %s cyc=%0d got en=%b ack=%b err=%b cmd=%b addr=%h ba=%h data=%h oe_n=%b dqm=%h want cyc=%0d en=%b err=%b cmd=%b addr=%h ba=%h data=%h oe_n=%b",
                   e.name, cyc, {aref_en, wr_en, rd_en}, aref_ack,
                   arb_err, sdram_cmd, sdram_addr, sdram_ba,
                   sdram_data, sdram_oe_n, sdram_dqm, e.cyc, e.en,
                   e.err, e.cmd, e.addr, e.ba, e.data, e.oe_n);
        end
      end
    end
  end

  task automatic pulse_done(input bit a, input bit w, input bit r);
    aref_done = a; wr_done = w; rd_done = r;
    step();
    aref_done = 0; wr_done = 0; rd_done = 0;
  endtask

  initial begin
    srst_n = 0; init_end = 0;
    init_cmd = 4'b0010; init_addr = 11'h400; init_ba = 2'd1;
    aref_cmd = 4'b0001; aref_addr = 11'h011; aref_ba = 2'd2;
    wr_cmd = 4'b0100; wr_addr = 11'h0aa; wr_ba = 2'd3;
    rd_cmd = 4'b0101; rd_addr = 11'h055; rd_ba = 2'd1;
    wr_data = 32'hdeadbeef; wr_oe_n = 0;
    aref_req = 0; wr_req = 0; rd_req = 0;
    aref_done = 0; wr_done = 0; rd_done = 0;

    step(); step();
    expect_at("reset_state", cyc, 3'b000, 0, P_NOP);
    srst_n = 1;
    expect_at("init_pins", cyc + 1, 3'b000, 0, P_INIT);
    repeat (20) step();
    expect_at("init_hold", cyc, 3'b000, 0, P_INIT);
    init_end = 1;
    expect_at("arbit_idle", cyc + 1, 3'b000, 0, P_INIT);
    expect_at("arbit_nop", cyc + 2, 3'b000, 0, P_NOP);
    step(); step();

    aref_req = 1; wr_req = 1; rd_req = 1;
    expect_at("aref_first", cyc + 1, 3'b100, 0, P_NOP);
    expect_at("aref_pins", cyc + 2, 3'b100, 0, P_AREF);
    step(); step();
    aref_req = 0;
    expect_at("aref_release", cyc + 1, 3'b000, 0, P_AREF);
    expect_at("wr_grant", cyc + 2, 3'b010, 0, P_NOP);
    expect_at("wr_pins", cyc + 3, 3'b010, 0, P_WR);
    pulse_done(1, 0, 0);
    step();
    expect_at("ignore_rd_done", cyc + 1, 3'b010, 0, P_WR);
    pulse_done(0, 0, 1);
    aref_req = 1;
    expect_at("no_preempt", cyc + 1, 3'b010, 0, P_WR);
    step();
    wr_req = 0;
    expect_at("wr_release", cyc + 1, 3'b000, 0, P_WR);
    expect_at("aref_after_wr", cyc + 2, 3'b100, 0, P_NOP);
    pulse_done(0, 1, 0);
    step();
    aref_req = 0;
    expect_at("aref_release2", cyc + 1, 3'b000, 0, P_AREF);
    expect_at("rd_grant", cyc + 2, 3'b001, 0, P_NOP);
    expect_at("rd_pins", cyc + 3, 3'b001, 0, P_RD);
    pulse_done(1, 0, 0);
    step();

    expect_at("rd_pre_timeout", cyc + TO - 1, 3'b001, 0, P_RD);
    expect_at("arb_err_pulse", cyc + TO, 3'b001, 1, P_RD);
    expect_at("timeout_release", cyc + TO + 1, 3'b000, 0, P_RD);
    expect_at("after_timeout", cyc + TO + 2, 3'b000, 0, P_NOP);
    repeat (TO) step();
    rd_req = 0;
    step(); step();

    wr_req = 1; rd_req = 1;
    expect_at("alt_0", cyc + 1, 3'b010, 0, P_NONE);
    expect_at("alt_1", cyc + 4, ALT1, 0, P_NONE);
    expect_at("alt_2", cyc + 7, 3'b010, 0, P_NONE);
    step(); step();
    pulse_done(0, 1, 1);
    step(); step();
    pulse_done(0, 1, 1);
    step();
    wr_req = 0; rd_req = 0;
    pulse_done(0, 1, 1);
    expect_at("idle_after_alt", cyc + 1, 3'b000, 0, P_NONE);
    step();

    wr_req = 1;
    expect_at("wr_before_rst", cyc + 2, 3'b010, 0, P_WR);
    step(); step();
    srst_n = 0; wr_req = 0;
    expect_at("rst_mid_grant", cyc + 1, 3'b000, 0, P_NOP);
    step();
    srst_n = 1; init_end = 0;
    expect_at("rst_back_init", cyc + 1, 3'b000, 0, P_INIT);
    step();
    init_end = 1; aref_req = 1;
    expect_at("init_to_arbit", cyc + 1, 3'b000, 0, P_INIT);
    expect_at("init_aref_first", cyc + 2, 3'b100, 0, P_NOP);
    step(); step();
    aref_req = 0;
    pulse_done(1, 0, 0);
    repeat (4) step();

    if (q.size() != 0) begin
      $display("FAIL undrained got %0d pending want 0", q.size());
      nerr += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
